// File: rtl/wb_multi_lane_pkg.sv
// Shared writeback defines and types for the multi-lane writeback stage.
`ifndef WB_MULTI_LANE_DEFINES
`define WB_MULTI_LANE_DEFINES
`define StallBus        5:0
`define Stop            1'b1
`define NoStop          1'b0
`define WB_LANE_WD      137
`define WB_TRACE_WD     70
`define WB_TO_RF_WD     38
`define HILO_BUS_WD     66
// Lane record field offsets (MSB to LSB: valid, hi_we, lo_we, hi, lo, pc, rf_we, rf_waddr, rf_wdata).
`define WB_VALID_BIT    136
`define WB_HI_WE_BIT    135
`define WB_LO_WE_BIT    134
`define WB_HI_LSB       102
`define WB_LO_LSB       70
`define WB_PC_LSB       38
`define WB_RF_WE_BIT    37
`define WB_RF_WADDR_LSB 32
`define WB_RF_WDATA_LSB 0
`endif

package wb_multi_lane_pkg;

  localparam int WB_MAX_LANES = 4;

  // Registered per-lane state; pc is not kept because the trace is captured at load time.
  typedef struct packed {
    logic        valid;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } wb_lane_state_t;

  // Number of set bits in a lane-valid vector.
  function automatic logic [2:0] lane_popcount(input logic [WB_MAX_LANES-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < WB_MAX_LANES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/wb_multi_lane_trace_fifo.sv
// Multi-push, single-pop circular trace buffer. Pushes beyond the free space
// (after this cycle's pop) are dropped youngest-first and flagged sticky.
module wb_trace_fifo
  import wb_multi_lane_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8,
  localparam int CNT_W      = $clog2(TRACE_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CNT_W-1:0]               push_cnt,
  input  logic [LANES*`WB_TRACE_WD-1:0]  push_data,
  input  logic                           pop,
  output logic [`WB_TRACE_WD-1:0]        head,
  output logic [CNT_W-1:0]               count,
  output logic                           ovf
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TRACE_DEPTH);

  logic [`WB_TRACE_WD-1:0] mem_r [TRACE_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic                    ovf_r;
  logic                    pop_s;
  logic [CNT_W-1:0]        space_s;
  logic [CNT_W-1:0]        accept_s;
  logic                    drop_s;

  // Work out how many pushes fit once this cycle's pop has freed its slot.
  always_comb begin
    pop_s    = 1'b0;
    space_s  = '0;
    accept_s = '0;
    drop_s   = 1'b0;
    if (pop && (count_r != '0)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    space_s = DEPTH_C - count_r + CNT_W'(pop_s);
    if (push_cnt > space_s) begin
      accept_s = space_s;
      drop_s   = 1'b1;
    end else begin
      accept_s = push_cnt;
      drop_s   = 1'b0;
    end
  end

  // Storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (CNT_W'(i) < accept_s) begin
          mem_r[wr_ptr_r + PTR_W'(i)] <= push_data[i*`WB_TRACE_WD +: `WB_TRACE_WD];
        end
      end
      // Depth is a power of two, so truncating the advance wraps the pointer.
      wr_ptr_r <= wr_ptr_r + PTR_W'(accept_s);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + accept_s - CNT_W'(pop_s);
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Head entry, forced to zero while the buffer is empty.
  always_comb begin
    head = '0;
    if (count_r != '0) begin
      head = mem_r[rd_ptr_r];
    end else begin
      head = '0;
    end
  end

  assign count = count_r;
  assign ovf   = ovf_r;

endmodule

// File: rtl/wb_multi_lane.sv
// Multi-lane writeback stage: latches LANES MEM->WB records, drives one RF
// write port per lane, merges HI/LO writes and serialises retirements into a
// trace FIFO feeding the single-retirement debug port.
module wb_multi_lane
  import wb_multi_lane_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8,
  parameter int LANE_WD     = `WB_LANE_WD,
  localparam int CNT_W      = $clog2(TRACE_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [`StallBus]              stall,
  input  logic                          flush,
  input  logic [LANES*LANE_WD-1:0]      mem_to_wb_bus,
  output logic [LANES*`WB_TO_RF_WD-1:0] wb_to_rf_bus,
  output logic [`HILO_BUS_WD-1:0]       hilo_bus,
  output logic [31:0]                   debug_wb_pc,
  output logic [3:0]                    debug_wb_rf_wen,
  output logic [4:0]                    debug_wb_rf_wnum,
  output logic [31:0]                   debug_wb_rf_wdata,
  output logic                          stall_req,
  output logic [31:0]                   retire_count,
  output logic                          trace_ovf
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TRACE_DEPTH);

  wb_lane_state_t                  lane_in_s [LANES];
  wb_lane_state_t                  lane_r    [LANES];
  logic [WB_MAX_LANES-1:0]         in_valid_s;
  logic [2:0]                      in_valid_cnt_s;
  logic                            load_s;
  logic                            bubble_s;
  logic [CNT_W-1:0]                push_cnt_s;
  logic [LANES*`WB_TRACE_WD-1:0]   push_data_s;
  int unsigned                     slot_s;
  logic                            fifo_pop_s;
  logic [`WB_TRACE_WD-1:0]         head_s;
  logic [CNT_W-1:0]                fifo_count_s;
  logic [CNT_W-1:0]                free_s;
  logic                            fifo_ovf_s;
  logic [31:0]                     retire_count_r;
  logic                            hi_we_s;
  logic                            lo_we_s;
  logic [31:0]                     hi_s;
  logic [31:0]                     lo_s;
  logic                            stall_unused_s;

  // Only stall[5:4] matter to this stage.
  assign stall_unused_s = ^stall[3:0];

  // Unpack the incoming lane records and gather their valid bits.
  always_comb begin
    in_valid_s = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_in_s[k]          = '0;
      lane_in_s[k].valid    = mem_to_wb_bus[k*LANE_WD + `WB_VALID_BIT];
      lane_in_s[k].hi_we    = mem_to_wb_bus[k*LANE_WD + `WB_HI_WE_BIT];
      lane_in_s[k].lo_we    = mem_to_wb_bus[k*LANE_WD + `WB_LO_WE_BIT];
      lane_in_s[k].hi       = mem_to_wb_bus[k*LANE_WD + `WB_HI_LSB +: 32];
      lane_in_s[k].lo       = mem_to_wb_bus[k*LANE_WD + `WB_LO_LSB +: 32];
      lane_in_s[k].rf_we    = mem_to_wb_bus[k*LANE_WD + `WB_RF_WE_BIT];
      lane_in_s[k].rf_waddr = mem_to_wb_bus[k*LANE_WD + `WB_RF_WADDR_LSB +: 5];
      lane_in_s[k].rf_wdata = mem_to_wb_bus[k*LANE_WD + `WB_RF_WDATA_LSB +: 32];
      in_valid_s[k]         = lane_in_s[k].valid;
    end
    in_valid_cnt_s = lane_popcount(in_valid_s);
  end

  // Decide between bubble, load and hold; flush beats the stall vector.
  always_comb begin
    bubble_s = 1'b0;
    load_s   = 1'b0;
    if (flush) begin
      bubble_s = 1'b1;
    end else if ((stall[4] == `Stop) && (stall[5] == `NoStop)) begin
      bubble_s = 1'b1;
    end else if (stall[4] == `NoStop) begin
      load_s = 1'b1;
    end else begin
      bubble_s = 1'b0;
      load_s   = 1'b0;
    end
  end

  // Compact the valid lanes' trace entries into ascending push slots.
  always_comb begin
    push_data_s = '0;
    slot_s      = 0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_in_s[k].valid) begin
        push_data_s[slot_s*`WB_TRACE_WD +: `WB_TRACE_WD] = mem_to_wb_bus[k*LANE_WD +: `WB_TRACE_WD];
        slot_s = slot_s + 1;
      end else begin
        slot_s = slot_s;
      end
    end
    if (load_s) begin
      push_cnt_s = CNT_W'(in_valid_cnt_s);
    end else begin
      push_cnt_s = '0;
    end
  end

  // Input register: reset, bubble, load or hold, in that priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) begin
        lane_r[k] <= '0;
      end
    end else if (bubble_s) begin
      for (int k = 0; k < LANES; k++) begin
        lane_r[k] <= '0;
      end
    end else if (load_s) begin
      for (int k = 0; k < LANES; k++) begin
        lane_r[k] <= lane_in_s[k];
      end
    end
  end

  // Retirement counter advances only on load events and wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count_r <= 32'd0;
    end else if (load_s) begin
      retire_count_r <= retire_count_r + {29'd0, in_valid_cnt_s};
    end
  end

  // Drain one trace entry every cycle the FIFO holds anything.
  always_comb begin
    fifo_pop_s = 1'b0;
    if (fifo_count_s != '0) begin
      fifo_pop_s = 1'b1;
    end else begin
      fifo_pop_s = 1'b0;
    end
  end

  wb_trace_fifo #(
    .LANES       (LANES),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_cnt  (push_cnt_s),
    .push_data (push_data_s),
    .pop       (fifo_pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .ovf       (fifo_ovf_s)
  );

  // Per-lane RF write ports; invalid lanes never assert a write.
  always_comb begin
    wb_to_rf_bus = '0;
    for (int k = 0; k < LANES; k++) begin
      wb_to_rf_bus[k*`WB_TO_RF_WD +: `WB_TO_RF_WD] =
        {lane_r[k].valid & lane_r[k].rf_we, lane_r[k].rf_waddr, lane_r[k].rf_wdata};
    end
  end

  // HI/LO merge: the youngest (highest) valid writer of each half wins.
  always_comb begin
    hi_we_s = 1'b0;
    lo_we_s = 1'b0;
    hi_s    = 32'd0;
    lo_s    = 32'd0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_r[k].valid && lane_r[k].hi_we) begin
        hi_we_s = 1'b1;
        hi_s    = lane_r[k].hi;
      end else begin
        hi_we_s = hi_we_s;
      end
      if (lane_r[k].valid && lane_r[k].lo_we) begin
        lo_we_s = 1'b1;
        lo_s    = lane_r[k].lo;
      end else begin
        lo_we_s = lo_we_s;
      end
    end
    hilo_bus = {hi_we_s, lo_we_s, hi_s, lo_s};
  end

  // Debug port follows the FIFO head; back-pressure when a full group cannot fit.
  always_comb begin
    debug_wb_pc       = head_s[`WB_PC_LSB +: 32];
    debug_wb_rf_wen   = {4{head_s[`WB_RF_WE_BIT]}};
    debug_wb_rf_wnum  = head_s[`WB_RF_WADDR_LSB +: 5];
    debug_wb_rf_wdata = head_s[`WB_RF_WDATA_LSB +: 32];
    free_s            = DEPTH_C - fifo_count_s;
    stall_req         = (free_s < CNT_W'(LANES));
  end

  assign retire_count = retire_count_r;
  assign trace_ovf    = fifo_ovf_s;

endmodule

// File: tb/tb_wb_multi_lane.sv
// Directed bench for wb_multi_lane (LANES=2, TRACE_DEPTH=4) with a queue-based
// behavioural model checked every cycle plus hand-computed literal checks.
module tb_wb_multi_lane;

  localparam int LANES = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } lane_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [5:0]        stall;
  lane_t             in0;
  lane_t             in1;
  logic [2*137-1:0]  mem_to_wb_bus;
  logic [2*38-1:0]   wb_to_rf_bus;
  logic [65:0]       hilo_bus;
  logic [31:0]       debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [4:0]        debug_wb_rf_wnum;
  logic [31:0]       debug_wb_rf_wdata;
  logic              stall_req;
  logic [31:0]       retire_count;
  logic              trace_ovf;

  assign mem_to_wb_bus = {in1, in0};

  always #5 clk = ~clk;

  wb_multi_lane #(.LANES(LANES), .TRACE_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .wb_to_rf_bus      (wb_to_rf_bus),
    .hilo_bus          (hilo_bus),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .stall_req         (stall_req),
    .retire_count      (retire_count),
    .trace_ovf         (trace_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: latched lanes, trace queue, retirement count, overflow flag.
  lane_t       m_lane [2];
  logic [69:0] m_q [$];
  logic [31:0] m_ret;
  logic        m_ovf;

  logic [75:0] e_rf;
  logic [65:0] e_hilo;
  logic [69:0] e_head;
  logic        e_hw, e_lw;
  logic [31:0] e_hi, e_lo;

  int          g;
  logic        adv;
  logic [31:0] got [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic lane_t mk(input logic v, input logic [31:0] pc, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd);
    lane_t l;
    l = '0;
    l.valid = v; l.pc = pc; l.rf_we = we; l.rf_waddr = wa; l.rf_wdata = wd;
    return l;
  endfunction

  // One clock: advance the model from the inputs seen at the edge, then wait for the falling edge.
  task automatic tick();
    lane_t nin [2];
    logic  load;
    @(posedge clk);
    nin[0] = in0;
    nin[1] = in1;
    load   = 1'b0;
    if (rst) begin
      m_lane[0] = '0; m_lane[1] = '0;
      m_q.delete();
      m_ret = 32'd0;
      m_ovf = 1'b0;
    end else begin
      if (flush) begin
        m_lane[0] = '0; m_lane[1] = '0;
      end else if (stall[4] && !stall[5]) begin
        m_lane[0] = '0; m_lane[1] = '0;
      end else if (!stall[4]) begin
        load = 1'b1;
        m_lane[0] = nin[0]; m_lane[1] = nin[1];
      end
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (load) begin
        for (int k = 0; k < 2; k++) begin
          if (nin[k].valid) begin
            m_ret = m_ret + 32'd1;
            if (m_q.size() < DEPTH)
              m_q.push_back({nin[k].pc, nin[k].rf_we, nin[k].rf_waddr, nin[k].rf_wdata});
            else
              m_ovf = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      e_rf = '0; e_hw = 1'b0; e_lw = 1'b0; e_hi = '0; e_lo = '0;
      for (int k = 0; k < 2; k++) begin
        e_rf[k*38 +: 38] = {m_lane[k].valid & m_lane[k].rf_we, m_lane[k].rf_waddr, m_lane[k].rf_wdata};
        if (m_lane[k].valid && m_lane[k].hi_we) begin e_hw = 1'b1; e_hi = m_lane[k].hi; end
        if (m_lane[k].valid && m_lane[k].lo_we) begin e_lw = 1'b1; e_lo = m_lane[k].lo; end
      end
      e_hilo = {e_hw, e_lw, e_hi, e_lo};
      e_head = (m_q.size() > 0) ? m_q[0] : 70'd0;
      check("model_rf_bus", wb_to_rf_bus, e_rf);
      check("model_hilo", hilo_bus, e_hilo);
      check("model_dbg_pc", debug_wb_pc, e_head[69:38]);
      check("model_dbg_wen", debug_wb_rf_wen, {4{e_head[37]}});
      check("model_dbg_wnum", debug_wb_rf_wnum, e_head[36:32]);
      check("model_dbg_wdata", debug_wb_rf_wdata, e_head[31:0]);
      check("model_stall_req", stall_req, (DEPTH - m_q.size()) < LANES);
      check("model_retire", retire_count, m_ret);
      check("model_ovf", trace_ovf, m_ovf);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 6'b000000; in0 = '0; in1 = '0;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_rf_bus", wb_to_rf_bus, 76'd0);
    check("reset_dbg_pc", debug_wb_pc, 32'd0);
    check("reset_stall_req", stall_req, 1'b0);
    check("reset_retire", retire_count, 32'd0);
    rst = 1'b0;

    // Dual retire
    in0 = mk(1'b1, 32'hBFC00000, 1'b1, 5'd2, 32'h11);
    in1 = mk(1'b1, 32'hBFC00004, 1'b1, 5'd3, 32'h22);
    tick();
    check("dual_rf_bus", wb_to_rf_bus, {1'b1, 5'd3, 32'h22, 1'b1, 5'd2, 32'h11});
    check("dual_pc0", debug_wb_pc, 32'hBFC00000);
    check("dual_retire", retire_count, 32'd2);
    in0 = '0; in1 = '0;
    tick();
    check("dual_pc1", debug_wb_pc, 32'hBFC00004);
    tick();

    // Hold then bubble
    in0 = mk(1'b1, 32'h100, 1'b1, 5'd4, 32'h44);
    in1 = mk(1'b1, 32'h104, 1'b1, 5'd5, 32'h55);
    tick();
    stall = 6'b110000;
    in0 = mk(1'b1, 32'h900, 1'b1, 5'd9, 32'h99);
    in1 = mk(1'b1, 32'h904, 1'b1, 5'd9, 32'h99);
    tick();
    check("hold_rf_bus", wb_to_rf_bus, {1'b1, 5'd5, 32'h55, 1'b1, 5'd4, 32'h44});
    check("hold_retire", retire_count, 32'd4);
    tick();
    check("hold_no_dup_trace", debug_wb_pc, 32'd0);
    stall = 6'b010000;
    tick();
    check("bubble_rf_bus", wb_to_rf_bus, 76'd0);
    check("bubble_retire", retire_count, 32'd4);

    // HI/LO merge
    stall = 6'b000000;
    in0 = mk(1'b1, 32'h200, 1'b0, 5'd0, 32'd0);
    in0.hi_we = 1'b1; in0.hi = 32'hAAAA0000;
    in1 = mk(1'b1, 32'h204, 1'b0, 5'd0, 32'd0);
    in1.hi_we = 1'b1; in1.hi = 32'hBBBB0000; in1.lo_we = 1'b1; in1.lo = 32'h5;
    tick();
    check("hilo_merge", hilo_bus, {1'b1, 1'b1, 32'hBBBB0000, 32'h5});
    in0 = '0; in1 = '0;
    tick(); tick();

    // Back-pressure ignored: overflow on the fourth consecutive load
    for (int i = 0; i < 4; i++) begin
      in0 = mk(1'b1, 32'h300 + 32'(8*i), 1'b1, 5'(i+1), 32'(i));
      in1 = mk(1'b1, 32'h304 + 32'(8*i), 1'b0, 5'(i+9), 32'(i+16));
      tick();
      if (i == 0) check("bp_stall_req_cnt2", stall_req, 1'b0);
      if (i == 1) check("bp_stall_req_cnt3", stall_req, 1'b1);
      if (i == 2) check("bp_ovf_not_yet", trace_ovf, 1'b0);
    end
    check("bp_ovf_set", trace_ovf, 1'b1);
    check("bp_retire", retire_count, 32'd14);
    check("bp_head", debug_wb_pc, 32'h30C);
    in0 = '0; in1 = '0;
    tick(); tick(); tick();
    check("bp_last_kept", debug_wb_pc, 32'h318);
    tick();
    check("bp_lane1_dropped", debug_wb_pc, 32'd0);

    // Back-pressure honoured after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_cleared_by_rst", trace_ovf, 1'b0);
    g = 0;
    got.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (g < 6) begin
        in0 = mk(1'b1, 32'h400 + 32'(8*g), 1'b1, 5'(g+1), 32'(g));
        in1 = mk(1'b1, 32'h404 + 32'(8*g), 1'b1, 5'(g+7), 32'(g+64));
        stall = stall_req ? 6'b010000 : 6'b000000;
        adv = !stall_req;
      end else begin
        in0 = '0; in1 = '0; stall = 6'b000000; adv = 1'b0;
      end
      tick();
      if (adv) g++;
      if (debug_wb_pc != 32'd0) got.push_back(debug_wb_pc);
    end
    check("honour_groups_done", g, 6);
    check("honour_trace_len", got.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < got.size()) check("honour_trace_pc", got[i], 32'h400 + 32'(4*i));
    end
    check("honour_no_ovf", trace_ovf, 1'b0);
    check("honour_retire", retire_count, 32'd12);

    // Flush squashes the incoming group while queued trace drains
    stall = 6'b000000;
    in0 = mk(1'b1, 32'h500, 1'b1, 5'd1, 32'hA);
    in1 = mk(1'b1, 32'h504, 1'b1, 5'd2, 32'hB);
    tick();
    flush = 1'b1;
    in0 = mk(1'b1, 32'h600, 1'b1, 5'd6, 32'hC);
    in1 = mk(1'b1, 32'h604, 1'b1, 5'd7, 32'hD);
    tick();
    check("flush_rf_bus", wb_to_rf_bus, 76'd0);
    check("flush_retire", retire_count, 32'd14);
    check("flush_drain", debug_wb_pc, 32'h504);
    flush = 1'b0;
    in0 = '0; in1 = '0;
    tick();
    check("flush_no_push", debug_wb_pc, 32'd0);

    // Reset mid-operation
    in0 = mk(1'b1, 32'h700, 1'b1, 5'd3, 32'h7);
    in1 = mk(1'b1, 32'h704, 1'b1, 5'd4, 32'h8);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_rf_bus", wb_to_rf_bus, 76'd0);
    check("midrst_dbg_pc", debug_wb_pc, 32'd0);
    check("midrst_retire", retire_count, 32'd0);
    rst = 1'b0;
    in0 = '0; in1 = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_multi_lane.md
Name: wb_multi_lane

Overview:
- Parametrised successor to the single-lane writeback stage.
- Latches LANES parallel MEM→WB lane records and drives one register-file write port per lane.
- Merges per-lane HI/LO writes into a single HI/LO commit bus.
- Serialises retired instructions into a trace FIFO so the debug port still reports one retirement per cycle; back-pressures the pipeline when that FIFO cannot absorb a full group.

Parameters:
- LANES, 2, number of parallel retire lanes (1..4); lane 0 is oldest.
- TRACE_DEPTH, 8, debug trace FIFO entries (power of two, ≥ LANES).
- LANE_WD, 137, per-lane record width; fixed, named for packing only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  `StallBus  pipeline stall vector; bits 4 and 5 are used.
- flush  in  1  squash incoming group.
- mem_to_wb_bus  in  LANES*LANE_WD  lane k occupies bits [k*LANE_WD +: LANE_WD].
  - Per-lane record, MSB→LSB: valid, hi_we, lo_we, hi[31:0], lo[31:0], pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0].
- wb_to_rf_bus  out  LANES*38  per-lane {rf_we, rf_waddr, rf_wdata}; rf_we is gated by lane valid.
- hilo_bus  out  66  merged {hi_we, lo_we, hi, lo}.
- debug_wb_pc  out  32  trace FIFO head pc; 0 when empty.
- debug_wb_rf_wen  out  4  {4{head rf_we}}; 0 when empty.
- debug_wb_rf_wnum  out  5  head rf_waddr.
- debug_wb_rf_wdata  out  32  head rf_wdata.
- stall_req  out  1  trace free entries < LANES.
- retire_count  out  32  total valid lanes retired.
- trace_ovf  out  1  sticky: a trace push was dropped.

Behaviour:
- Input register update, in priority order:
  1. rst → all zero.
  2. flush → zero (bubble).
  3. stall[4]==`Stop && stall[5]==`NoStop → zero (bubble).
  4. stall[4]==`NoStop → load mem_to_wb_bus.
  5. Otherwise → hold.
- "Load event": the cycle rule 4 fires. Only load events push to the trace FIFO and count retirements. A held register never re-pushes.
- RF outputs: combinational from the register, 0-cycle latency after load. Invalid lanes drive rf_we=0.
- Same rf_waddr written by several lanes in one group: all ports assert. The register file resolves the collision; the highest lane is the youngest and wins. This block does no arbitration.
- hilo_bus merge:
  - hi_we = OR of valid & hi_we across lanes; hi = value from the highest valid lane with hi_we.
  - lo is merged the same way, independently.
  - Neither written → 66'b0.
- Trace FIFO:
  - On a load event, push one entry per valid lane in ascending lane order, including lanes with rf_we=0.
  - Entry = {pc, rf_we, rf_waddr, rf_wdata}.
  - Pop one entry every cycle the FIFO is non-empty.
  - count_next = count + pushes − pop.
  - Debug outputs are combinational from the head, so a 1-lane group's trace appears in the same cycle as its RF write.
  - Pointers wrap modulo TRACE_DEPTH.
- Overflow: if the FIFO would exceed TRACE_DEPTH, accept pushes up to full (after this cycle's pop), drop the remaining youngest lanes, and set trace_ovf. trace_ovf clears only on rst.
- stall_req = (TRACE_DEPTH − count) < LANES, combinational from the registered count. The hazard unit ORs it into stall[4]. With correct use, overflow never occurs.
- retire_count: +popcount(valid) on each load event; wraps at 2^32.
- flush does not clear the FIFO, retire_count, or trace_ovf; already-retired work stays retired.
- Reset mid-operation: FIFO emptied, all outputs 0 on the next edge.
- LANES=1 reproduces the single-lane stage exactly: debug_* equal the RF port, and stall_req never asserts once TRACE_DEPTH ≥ 2.

Decomposition:
- Shared defines header:
  - `WB_LANE_WD (137)
  - lane field offsets
  - `WB_TRACE_WD (70)
  - `WB_TO_RF_WD (38)
  - `HILO_BUS_WD (66)
  - `Stop / `NoStop (existing)
- Sub-module wb_trace_fifo(clk, rst, push_cnt, push_data[LANES*70], pop, head, count, ovf): multi-push, single-pop circular buffer.
- Lane unpacking and the HI/LO merge stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles → all outputs 0, count 0, stall_req=0.
- Dual retire:
  - Stimulus: lane0 {pc 0xBFC00000, r2←0x11}, lane1 {pc 0xBFC00004, r3←0x22}, both valid, one load.
  - Response: both RF ports active next cycle; debug_wb_pc 0xBFC00000, then 0xBFC00004 the following cycle; retire_count=2.
- Bubble vs hold:
  - stall[5:4]=2'b01 → register zeroed; no push.
  - stall[5:4]=2'b11 → contents held; retire_count unchanged; no duplicate trace.
- HI/LO merge:
  - Stimulus: lane0 hi_we hi=0xAAAA0000; lane1 hi_we hi=0xBBBB0000, lo_we lo=0x5.
  - Response: hilo_bus = {1,1,0xBBBB0000,0x5}.
- Back-pressure:
  - Stimulus: TRACE_DEPTH=4; 2-lane groups on consecutive loads with stall ignored.
  - Response: stall_req rises when count=3; a forced load at count=4 sets trace_ovf and drops lane1.
  - With stall honoured: no overflow, and debug emits every pc in order.
- Flush: flush=1 concurrent with a valid group → no RF write, no push; an already-queued trace still drains.
